// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the
// Memory stage (CPU port) and the DMA/loader port.
package dmem_arb_pkg;

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } arb_state_t;

   // DataMemory ADTP encoding for a full-word access; DMA is always word-sized.
   localparam logic ADTP_WORD = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port DataMemory arbiter: CPU has priority, DMA gets locked bursts
// bounded by MAX_BURST, and a starvation counter bounds how long DMA waits.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int D_WIDTH      = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int MAX_BURST    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic               cpu_atype,
   input  logic [D_WIDTH-1:0] cpu_addr,
   input  logic [D_WIDTH-1:0] cpu_wdata,
   output logic [D_WIDTH-1:0] cpu_rdata,
   output logic               stall_m,
   input  logic               dma_req,
   input  logic               dma_we,
   input  logic [D_WIDTH-1:0] dma_addr,
   input  logic [D_WIDTH-1:0] dma_wdata,
   input  logic               dma_last,
   output logic               dma_gnt,
   output logic [D_WIDTH-1:0] dma_rdata,
   output logic               dma_rvalid,
   output logic               mem_we,
   output logic               mem_atype,
   output logic [D_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic [D_WIDTH-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST - 1);

   arb_state_t    state_r;
   arb_state_t    state_nxt_s;
   logic [SW-1:0] starve_cnt_r;
   logic [BW-1:0] beat_cnt_r;
   logic          dma_exit_s;

   // Ownership state plus starvation and burst-length counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= CPU_OWN;
         starve_cnt_r <= {SW{1'b0}};
         beat_cnt_r   <= {BW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            CPU_OWN: begin
               beat_cnt_r <= {BW{1'b0}};
               if (state_nxt_s == DMA_OWN) begin
                  starve_cnt_r <= {SW{1'b0}};
               end else if (cpu_req && dma_req && (starve_cnt_r != STARVE_MAX)) begin
                  starve_cnt_r <= starve_cnt_r + SW'(1);
               end else begin
                  starve_cnt_r <= starve_cnt_r;
               end
            end
            DMA_OWN: begin
               starve_cnt_r <= {SW{1'b0}};
               // Staying in DMA_OWN implies a beat was accepted this cycle.
               if (dma_exit_s) begin
                  beat_cnt_r <= {BW{1'b0}};
               end else begin
                  beat_cnt_r <= beat_cnt_r + BW'(1);
               end
            end
            default: begin
               starve_cnt_r <= {SW{1'b0}};
               beat_cnt_r   <= {BW{1'b0}};
            end
         endcase
      end
   end

   // Next-state decision, memory mux and handshake; all outputs forced low in reset.
   always_comb begin
      state_nxt_s = state_r;
      dma_exit_s  = 1'b0;
      cpu_rdata   = {D_WIDTH{1'b0}};
      stall_m     = 1'b0;
      dma_gnt     = 1'b0;
      dma_rdata   = {D_WIDTH{1'b0}};
      dma_rvalid  = 1'b0;
      mem_we      = 1'b0;
      mem_atype   = 1'b0;
      mem_addr    = {D_WIDTH{1'b0}};
      mem_wdata   = {D_WIDTH{1'b0}};
      case (state_r)
         CPU_OWN: begin
            if (dma_req && (!cpu_req || (starve_cnt_r == STARVE_MAX))) begin
               state_nxt_s = DMA_OWN;
            end else begin
               state_nxt_s = CPU_OWN;
            end
            if (rst_n) begin
               mem_we    = cpu_req & cpu_we;
               mem_atype = cpu_atype;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               cpu_rdata = mem_rdata;
            end else begin
               mem_we = 1'b0;
            end
         end
         DMA_OWN: begin
            if (!dma_req || dma_last || (beat_cnt_r == BEAT_MAX)) begin
               state_nxt_s = CPU_OWN;
               dma_exit_s  = 1'b1;
            end else begin
               state_nxt_s = DMA_OWN;
            end
            if (rst_n) begin
               mem_we     = dma_req & dma_we;
               mem_atype  = ADTP_WORD;
               mem_addr   = dma_addr;
               mem_wdata  = dma_wdata;
               dma_gnt    = dma_req;
               dma_rvalid = dma_req & ~dma_we;
               dma_rdata  = mem_rdata;
               stall_m    = cpu_req;
            end else begin
               mem_we = 1'b0;
            end
         end
         default: begin
            state_nxt_s = CPU_OWN;
         end
      endcase
   end

endmodule
